// File: rtl/raccoon_round_ctrl.sv
// Round controller for the raccoon crossing game: per-car collision, goal detection,
// lives/score/level tracking, timed invulnerability and a timed game-over hold.
module raccoon_round_ctrl #(
    parameter int unsigned N_CARS        = 4,
    parameter int unsigned COORD_W       = 10,
    parameter int unsigned PLAYER_W      = 32,
    parameter int unsigned PLAYER_H      = 32,
    parameter int unsigned CAR_W         = 64,
    parameter int unsigned CAR_H         = 32,
    parameter int unsigned LIVES         = 4,
    parameter int unsigned LIFE_W        = 4,
    parameter int unsigned SCORE_W       = 8,
    parameter int unsigned LEVEL_W       = 3,
    parameter int unsigned GOAL_Y        = 0,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned OVER_FRAMES   = 120
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic                        i_Frame_Tick,
    input  logic                        i_Game_Start,
    input  logic [COORD_W-1:0]          i_Player_X,
    input  logic [COORD_W-1:0]          i_Player_Y,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_X,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_Y,
    input  logic [N_CARS-1:0]           i_Car_En,
    output logic [2:0]                  o_State,
    output logic                        o_Game_Active,
    output logic [LIFE_W-1:0]           o_Lives,
    output logic [SCORE_W-1:0]          o_Score,
    output logic [LEVEL_W-1:0]          o_Level,
    output logic                        o_Invuln,
    output logic                        o_Hit,
    output logic                        o_Respawn
);

    localparam int unsigned TMR_MAX = (INVULN_FRAMES > OVER_FRAMES) ? INVULN_FRAMES : OVER_FRAMES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned CW1     = COORD_W + 1;
    localparam int unsigned SW1     = SCORE_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_INVULN    = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [LIFE_W-1:0]    lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 coll_q, coll_d;
    logic                 goal_q, goal_d;
    logic                 hit_q, hit_d;
    logic                 resp_q, resp_d;
    logic                 invuln_q, invuln_d;
    logic                 active_q, active_d;
    logic [N_CARS-1:0]    car_hit_c;
    logic [SW1-1:0]       score_sum_c;
    logic [CW1-1:0]       px_c, py_c;

    // Box overlap per car, widened by one bit so edge sums never wrap.
    assign px_c = CW1'(i_Player_X);
    assign py_c = CW1'(i_Player_Y);

    for (genvar k = 0; k < N_CARS; k++) begin : g_car
        logic [CW1-1:0] cx, cy;
        assign cx = CW1'(i_Car_X[k*COORD_W +: COORD_W]);
        assign cy = CW1'(i_Car_Y[k*COORD_W +: COORD_W]);
        assign car_hit_c[k] = i_Car_En[k]
                            && (px_c < cx + CW1'(CAR_W))
                            && (px_c + CW1'(PLAYER_W) > cx)
                            && (py_c < cy + CW1'(CAR_H))
                            && (py_c + CW1'(PLAYER_H) > cy);
    end

    assign score_sum_c = SW1'(score_q) + SW1'(level_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        score_d  = score_q;
        level_d  = level_q;
        timer_d  = timer_q;
        hit_d    = 1'b0;
        resp_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Game_Start) begin
                    state_d = ST_RUNNING;
                    lives_d = LIFE_W'(LIVES);
                    level_d = LEVEL_W'(1);
                    score_d = '0;
                    resp_d  = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (goal_q) begin
                    score_d = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
                    if (level_q != '1) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    resp_d  = 1'b1;
                    state_d = ST_LEVEL_UP;
                end else if (coll_q) begin
                    hit_d = 1'b1;
                    if (lives_q > LIFE_W'(1)) begin
                        lives_d = lives_q - LIFE_W'(1);
                        resp_d  = 1'b1;
                        timer_d = TMR_W'(INVULN_FRAMES);
                        state_d = ST_INVULN;
                    end else begin
                        lives_d = '0;
                        timer_d = TMR_W'(OVER_FRAMES);
                        state_d = ST_GAME_OVER;
                    end
                end
            end
            ST_INVULN: begin
                if (i_Frame_Tick) begin
                    timer_d = timer_q - TMR_W'(1);
                    if (timer_q == TMR_W'(1)) begin
                        state_d = ST_RUNNING;
                    end
                end
            end
            ST_LEVEL_UP: begin
                if (i_Frame_Tick) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_GAME_OVER: begin
                if (i_Frame_Tick) begin
                    timer_d = timer_q - TMR_W'(1);
                    if (timer_q == TMR_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Drop any overlap sampled before a transition (e.g. pre-respawn position).
        coll_d = |car_hit_c;
        goal_d = (i_Player_Y <= COORD_W'(GOAL_Y));
        if (state_d != state_q) begin
            coll_d = 1'b0;
            goal_d = 1'b0;
        end

        invuln_d = (state_d == ST_INVULN);
        active_d = (state_d == ST_RUNNING) || (state_d == ST_INVULN) || (state_d == ST_LEVEL_UP);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            lives_q  <= '0;
            score_q  <= '0;
            level_q  <= '0;
            timer_q  <= '0;
            coll_q   <= 1'b0;
            goal_q   <= 1'b0;
            hit_q    <= 1'b0;
            resp_q   <= 1'b0;
            invuln_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            coll_q   <= coll_d;
            goal_q   <= goal_d;
            hit_q    <= hit_d;
            resp_q   <= resp_d;
            invuln_q <= invuln_d;
            active_q <= active_d;
        end
    end

    assign o_State       = state_q;
    assign o_Lives       = lives_q;
    assign o_Score       = score_q;
    assign o_Level       = level_q;
    assign o_Hit         = hit_q;
    assign o_Respawn     = resp_q;
    assign o_Invuln      = invuln_q;
    assign o_Game_Active = active_q;

endmodule
